// File: rtl/movavg_seq_ctrl.sv
// ---------------------------------------------------------------------------
// movavg_seq_ctrl
//
// Sequencer that drives a moving-average filter for one line of samples.
// A cfg_go pulse in IDLE latches the line configuration, pulses
// flt_start_act, streams cfg_len samples from the source into the filter
// (registered, one cycle of latency), then waits until the filter has
// produced as many outputs as inputs were sent and pulses done.
//
// Optional feature macro: MOVAVG_SEQ_CTRL_TIMEOUT_EN
//   Defined   : drain watchdog; TIMEOUT_CYC cycles without a filter output
//               while draining sets err_timeout and finishes the line.
//   Undefined : no watchdog, err_timeout tied low, drain waits forever.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   cfg_go                    start pulse (accepted only in IDLE, len != 0)
//   cfg_en / cfg_win / cfg_len filter enable, window code (2/4/8/16), length
//   src_valid/src_data/src_ready   sample source handshake
//   flt_start_act             one-cycle filter start strobe
//   flt_movavg_en / flt_movavgwin_param  filter configuration (shadowed)
//   flt_vald_din / flt_data_in     registered samples to the filter
//   flt_valid_out             filter output strobe
//   busy, done                status; done is a one-cycle pulse
//   out_cnt                   filter outputs counted (saturates at length)
//   err_underflow             sticky: source starved mid-line
//   err_timeout               sticky: drain watchdog expired
// ---------------------------------------------------------------------------
`ifndef DATAWIDTH
`define DATAWIDTH 12
`endif

module movavg_seq_ctrl #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_go,
  input  logic                  cfg_en,
  input  logic [1:0]            cfg_win,
  input  logic [10:0]           cfg_len,
  input  logic                  src_valid,
  input  logic [`DATAWIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  flt_start_act,
  output logic                  flt_movavg_en,
  output logic [1:0]            flt_movavgwin_param,
  output logic                  flt_vald_din,
  output logic [`DATAWIDTH-1:0] flt_data_in,
  input  logic                  flt_valid_out,
  output logic                  busy,
  output logic                  done,
  output logic [10:0]           out_cnt,
  output logic                  err_underflow,
  output logic                  err_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state;
  logic        sh_en;
  logic [1:0]  sh_win;
  logic [10:0] sh_len;
  logic [10:0] in_cnt;
  logic        go_accept;
  logic        accept;
  logic        last_beat;
  logic        count_out;
  logic        drain_complete;
  logic        wd_hit;

  // Strobes and status are pure decodes of the state register, so they
  // come out of reset low without extra flops.
  assign src_ready     = (state == S_FEED);
  assign flt_start_act = (state == S_START);
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

  assign flt_movavg_en       = sh_en;
  assign flt_movavgwin_param = sh_win;

  assign go_accept      = (state == S_IDLE) && cfg_go && (cfg_len != 11'd0);
  assign accept         = src_valid && src_ready;
  assign last_beat      = accept && ((in_cnt + 11'd1) == sh_len);
  assign drain_complete = (out_cnt == sh_len);

  // Filter outputs only count while a line is in flight; stray pulses in
  // IDLE/START/DONE are dropped, and the count saturates at the length.
  assign count_out = flt_valid_out && ((state == S_FEED) || (state == S_DRAIN))
                     && (out_cnt != sh_len);

`ifdef MOVAVG_SEQ_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  // Fires on the cycle the quiet-cycle count would reach TIMEOUT_CYC.
  assign wd_hit = (state == S_DRAIN) && !flt_valid_out
                  && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog counts consecutive DRAIN cycles without a filter output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if ((state != S_DRAIN) || flt_valid_out)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WD_W'(1);

      if (go_accept)
        err_timeout <= 1'b0;
      else if (wd_hit && !drain_complete)
        err_timeout <= 1'b1;
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Main sequencer: shadows, counters, sample register and FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      sh_en         <= 1'b0;
      sh_win        <= 2'd0;
      sh_len        <= 11'd0;
      in_cnt        <= 11'd0;
      out_cnt       <= 11'd0;
      err_underflow <= 1'b0;
      flt_vald_din  <= 1'b0;
      flt_data_in   <= '0;
    end else begin
      flt_vald_din <= accept;
      if (accept)
        flt_data_in <= src_data;

      if (count_out)
        out_cnt <= out_cnt + 11'd1;

      case (state)
        S_IDLE: begin
          if (go_accept) begin
            sh_en         <= cfg_en;
            sh_win        <= cfg_win;
            sh_len        <= cfg_len;
            in_cnt        <= 11'd0;
            out_cnt       <= 11'd0;
            err_underflow <= 1'b0;
            state         <= S_START;
          end
        end
        S_START: state <= S_FEED;
        S_FEED: begin
          if (accept)
            in_cnt <= in_cnt + 11'd1;
          if (last_beat)
            state <= S_DRAIN;
          // A gap is only an underflow once the line has started flowing.
          if ((in_cnt != 11'd0) && !src_valid)
            err_underflow <= 1'b1;
        end
        S_DRAIN: begin
          if (drain_complete || wd_hit)
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
